// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// A single clock domain with a pixel clock-enable (no derived clock) drives the
// horizontal/vertical counters. Sync, blank, DE and strobes are registered from
// the next (x,y), so they always line up with x_pixel/y_pixel.
// Optional feature: define VGA_TG_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int COORD_W  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               pix_ce,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic               vblank,
    output logic [COORD_W-1:0] x_pixel,
    output logic [COORD_W-1:0] y_pixel,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_TG_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Region bounds are one bit wider than the coordinates so that an end bound
    // equal to 2**COORD_W is still representable.
    localparam logic [COORD_W:0] H_ACT_W  = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0] HS_START = (COORD_W+1)'(H_ACTIVE + H_FP);
    localparam logic [COORD_W:0] HS_END   = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W:0] V_ACT_W  = (COORD_W+1)'(V_ACTIVE);
    localparam logic [COORD_W:0] VS_START = (COORD_W+1)'(V_ACTIVE + V_FP);
    localparam logic [COORD_W:0] VS_END   = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [COORD_W-1:0] H_MAX   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_MAX   = COORD_W'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_param_check
        $fatal(1, "vga_timing_gen: illegal timing parameter set");
    end

    logic [1:0]         rst_sync;
    logic               rst_n_int;
    logic [DIV_W-1:0]   div;
    logic               div_last;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic               h_last;
    logic               v_last;
    logic               hs_act;
    logic               vs_act;
    logic               de_next;
    logic               vb_next;
    logic               at_origin;

    // Reset synchroniser: asserts immediately, releases two clocks after reset rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_int = rst_sync[1];

    // Pixel strobe comes straight from the divider; gated by en so a frozen generator never strobes.
    assign div_last = (div == DIV_MAX);
    assign pix_ce   = en && div_last;

    // Pixel-rate divider; holds its phase while en is low.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int)  div <= '0;
        else if (en)     div <= div_last ? '0 : div + 1'b1;
    end

    // Next raster position and the decoded regions at that position.
    always_comb begin
        h_last    = (h_cnt == H_MAX);
        v_last    = (v_cnt == V_MAX);
        x_next    = h_last ? '0 : h_cnt + 1'b1;
        y_next    = v_cnt;
        if (h_last) y_next = v_last ? '0 : v_cnt + 1'b1;
        hs_act    = ({1'b0, x_next} >= HS_START) && ({1'b0, x_next} < HS_END);
        vs_act    = ({1'b0, y_next} >= VS_START) && ({1'b0, y_next} < VS_END);
        de_next   = ({1'b0, x_next} < H_ACT_W) && ({1'b0, y_next} < V_ACT_W);
        vb_next   = ({1'b0, y_next} >= V_ACT_W);
        at_origin = (x_next == '0) && (y_next == '0);
    end

    // Counters and registered outputs advance together on each pixel strobe.
    // The internal counters reset to the last position so the first strobe lands on (0,0).
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            h_cnt       <= H_MAX;
            v_cnt       <= V_MAX;
            x_pixel     <= '0;
            y_pixel     <= '0;
            de          <= 1'b0;
            vblank      <= 1'b0;
            h_sync      <= ~HS_ON;
            v_sync      <= ~VS_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            h_cnt       <= x_next;
            v_cnt       <= y_next;
            x_pixel     <= x_next;
            y_pixel     <= y_next;
            de          <= de_next;
            vblank      <= vb_next;
            h_sync      <= hs_act ? HS_ON : ~HS_ON;
            v_sync      <= vs_act ? VS_ON : ~VS_ON;
            line_start  <= (x_next == '0);
            frame_start <= at_origin;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TG_FRAME_CNT_EN
    // Frame counter steps on the same edge that raises frame_start; wraps naturally.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int)              frame_cnt <= '0;
        else if (pix_ce && at_origin) frame_cnt <= frame_cnt + 1'b1;
    end
`endif

endmodule
